lfsr_generator: RTL and testbench

LFSR_GENERATOR -- requirements
Module: lfsr_generator

---
 rtl/lfsr_generator.sv | 107 ++++++++++
 tb/tb_lfsr_generator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lfsr_generator.sv
// Fibonacci/Galois LFSR with seed load, zero-seed rejection and validity flag.
// Define LFSR_PERIOD_CNT_EN to build in the period measurement counter.
module lfsr_generator #(
  parameter int unsigned          WIDTH  = 8,
  parameter logic [WIDTH-1:0]     TAPS   = 8'hB8,
  parameter bit                   GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] w,
  output logic             valid,
  output logic             seed_err,
  output logic             period_done,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] r_w;
  logic             r_valid;
  logic             r_seed_err;

  logic             w_fib_fb;
  logic [WIDTH-1:0] w_fib_nxt;
  logic [WIDTH-1:0] w_gal_nxt;
  logic [WIDTH-1:0] w_step;
  logic             w_seed_ok;
  logic [WIDTH-1:0] w_load;

  // next state for one shift in the selected form, plus the load value
  always_comb begin
    w_fib_fb  = ^(r_w & TAPS);
    w_fib_nxt = {r_w[WIDTH-2:0], w_fib_fb};
    w_gal_nxt = (r_w >> 1) ^ (r_w[0] ? TAPS : '0);
    w_step    = GALOIS ? w_gal_nxt : w_fib_nxt;
    w_seed_ok = |seed;
    w_load    = w_seed_ok ? seed : ONES;
  end

  // shift register, validity flag and zero-seed pulse; load beats step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w        <= ONES;
      r_valid    <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= sel & ~w_seed_ok;
      if (sel) begin
        r_w     <= w_load;
        r_valid <= 1'b1;
      end else if (en) begin
        r_w <= w_step;
      end
    end
  end

  assign w        = r_w;
  assign valid    = r_valid;
  assign seed_err = r_seed_err;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_pdone;
  logic [WIDTH-1:0] w_cnt_inc;

  // saturating count+1, shared by counter and period capture
  always_comb begin
    w_cnt_inc = (r_cnt == ONES) ? ONES : r_cnt + 1'b1;
  end

  // count steps; on return to the stored seed latch the period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seed   <= ONES;
      r_cnt    <= '0;
      r_period <= '0;
      r_pdone  <= 1'b0;
    end else begin
      r_pdone <= 1'b0;
      if (sel) begin
        r_seed <= w_load;
        r_cnt  <= '0;
      end else if (en) begin
        if (w_step == r_seed) begin
          r_pdone  <= 1'b1;
          r_period <= w_cnt_inc;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign period_done = r_pdone;
  assign period      = r_period;
`else
  assign period_done = 1'b0;
  assign period      = '0;
`endif

endmodule

// File: tb/tb_lfsr_generator.sv
// Scoreboard bench for lfsr_generator: Fibonacci and Galois instances.
// Period expectations follow LFSR_PERIOD_CNT_EN.
module tb_lfsr_generator;

`ifdef LFSR_PERIOD_CNT_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif
  localparam logic [3:0] P15 = PC ? 4'd15 : 4'd0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       f_sel = 1'b0, f_en = 1'b0;
  logic [3:0] f_seed = 4'h0;
  logic [3:0] f_w, f_per;
  logic       f_v, f_err, f_pd;
  logic       g_sel = 1'b0, g_en = 1'b0;
  logic [3:0] g_seed = 4'h0;
  logic [3:0] g_w, g_per;
  logic       g_v, g_err, g_pd;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] w;
    logic       v;
    logic       e;
    logic       pd;
    logic [3:0] per;
  } exp_t;

  exp_t q[$];

  logic [3:0] fib_tab [15] = '{4'b1110, 4'b1100, 4'b1000, 4'b0001,
    4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
    4'b0101, 4'b1011, 4'b0111, 4'b1111};
  logic [3:0] gal_tab [15] = '{4'b1001, 4'b1101, 4'b1111, 4'b1110,
    4'b0111, 4'b1010, 4'b0101, 4'b1011, 4'b1100, 4'b0110, 4'b0011,
    4'b1000, 4'b0100, 4'b0010, 4'b0001};

  always #5 clk = ~clk;

  lfsr_generator #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(1'b0)) u_fib (
    .clk(clk), .reset(reset), .sel(f_sel), .seed(f_seed), .en(f_en),
    .w(f_w), .valid(f_v), .seed_err(f_err),
    .period_done(f_pd), .period(f_per)
  );

  lfsr_generator #(.WIDTH(4), .TAPS(4'b1001), .GALOIS(1'b1)) u_gal (
    .clk(clk), .reset(reset), .sel(g_sel), .seed(g_seed), .en(g_en),
    .w(g_w), .valid(g_v), .seed_err(g_err),
    .period_done(g_pd), .period(g_per)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input logic [3:0] w, input logic v,
                     input logic er, input logic pd, input logic [3:0] per);
    check({e.tag, ".w"},   32'(w),   32'(e.w));
    check({e.tag, ".v"},   32'(v),   32'(e.v));
    check({e.tag, ".err"}, 32'(er),  32'(e.e));
    check({e.tag, ".pd"},  32'(pd),  32'(e.pd));
    check({e.tag, ".per"}, 32'(per), 32'(e.per));
  endtask

  task automatic f_cyc(input logic s, input logic e, input logic [3:0] sd,
                       input exp_t x);
    exp_t y;
    @(negedge clk);
    f_sel = s; f_en = e; f_seed = sd;
    q.push_back(x);
    @(posedge clk);
    #1;
    y = q.pop_front();
    cmp(y, f_w, f_v, f_err, f_pd, f_per);
  endtask

  task automatic g_cyc(input logic s, input logic e, input logic [3:0] sd,
                       input exp_t x);
    exp_t y;
    @(negedge clk);
    g_sel = s; g_en = e; g_seed = sd;
    q.push_back(x);
    @(posedge clk);
    #1;
    y = q.pop_front();
    cmp(y, g_w, g_v, g_err, g_pd, g_per);
  endtask

  initial begin
    logic [3:0] per;
    #1 reset = 1'b0;
    #1;
    check("rst.w",   32'(f_w),   32'hF);
    check("rst.v",   32'(f_v),   32'h0);
    check("rst.per", 32'(f_per), 32'h0);
    check("rst.err", 32'(f_err), 32'h0);
    check("rst.pd",  32'(f_pd),  32'h0);
    check("rst.gw",  32'(g_w),   32'hF);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    f_cyc(0, 0, 4'h0, '{"idle", 4'hF, 0, 0, 0, 4'h0});
    f_cyc(1, 0, 4'hF, '{"ld1111", 4'hF, 1, 0, 0, 4'h0});
    for (int i = 0; i < 15; i++)
      f_cyc(0, 1, 4'h0, '{$sformatf("fib%0d", i), fib_tab[i], 1, 0,
        (i == 14) ? PC : 1'b0, (i == 14) ? P15 : 4'h0});
    per = P15;
    f_cyc(0, 0, 4'h0, '{"pdfall", 4'hF, 1, 0, 0, per});

    f_cyc(1, 0, 4'h0, '{"ld0", 4'hF, 1, 1, 0, per});
    f_cyc(0, 0, 4'h0, '{"errfall", 4'hF, 1, 0, 0, per});

    f_cyc(1, 1, 4'h5, '{"selpri", 4'h5, 1, 0, 0, per});
    for (int i = 0; i < 3; i++)
      f_cyc(0, 0, 4'h0, '{$sformatf("hold%0d", i), 4'h5, 1, 0, 0, per});

    for (int i = 0; i < 5; i++)
      f_cyc(0, 1, 4'h0, '{$sformatf("pre%0d", i), fib_tab[(i + 12) % 15],
        1, 0, 0, per});

    #2 reset = 1'b0;
    #1;
    check("midrst.w",   32'(f_w),   32'hF);
    check("midrst.v",   32'(f_v),   32'h0);
    check("midrst.per", 32'(f_per), 32'h0);
    check("midrst.pd",  32'(f_pd),  32'h0);
    reset = 1'b1;
    for (int i = 0; i < 15; i++)
      f_cyc(0, 1, 4'h0, '{$sformatf("post%0d", i), fib_tab[i], 0, 0,
        (i == 14) ? PC : 1'b0, (i == 14) ? P15 : 4'h0});
    @(negedge clk);
    f_en = 1'b0;

    g_cyc(1, 0, 4'h1, '{"gld", 4'h1, 1, 0, 0, 4'h0});
    for (int i = 0; i < 15; i++)
      g_cyc(0, 1, 4'h0, '{$sformatf("gal%0d", i), gal_tab[i], 1, 0,
        (i == 14) ? PC : 1'b0, (i == 14) ? P15 : 4'h0});
    g_cyc(0, 0, 4'h0, '{"ghold", 4'h1, 1, 0, 0, P15});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
